// File: rtl/display_fill_engine.sv
// display_fill_engine: rectangle fill / line-pattern engine.
// Software loads a rectangle, colours, a line pattern and a mode through the
// register port. A start command makes the engine write one palette index per
// cycle to the framebuffer port, with valid/ready backpressure. The rectangle
// is clipped to the screen edges.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   reg_addr         0 ORIGIN {y0,x0}, 1 SIZE {h,w}, 2 COLOR {bg,fg},
//                    3 PATTERN, 4 CONTROL {mode[3:2], abort[1], start[0]}
//   reg_wr_data      register write data
//   reg_wr_en        register write strobe
//   status           [0] busy, [1] done (sticky), [2] error (sticky),
//                    [31:8] accepted pixel writes (wraps at 2^24)
//   fb_pxl_index     linear pixel address y*RESOLUTION_X + x
//   fb_pxl_value     palette index to write
//   fb_wr_en         write valid
//   fb_wr_ready      framebuffer accepts the write this cycle
module display_fill_engine #(
  parameter int unsigned RESOLUTION_X   = 400,
  parameter int unsigned RESOLUTION_Y   = 300,
  parameter int unsigned PALETTE_LENGTH = 256,
  parameter int unsigned PATTERN_BITS   = 32
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [2:0]                                    reg_addr,
  input  logic [31:0]                                   reg_wr_data,
  input  logic                                          reg_wr_en,
  output logic [31:0]                                   status,
  output logic [$clog2(RESOLUTION_X*RESOLUTION_Y)-1:0]  fb_pxl_index,
  output logic [$clog2(PALETTE_LENGTH)-1:0]             fb_pxl_value,
  output logic                                          fb_wr_en,
  input  logic                                          fb_wr_ready
);

  localparam int unsigned AW = $clog2(RESOLUTION_X*RESOLUTION_Y);
  localparam int unsigned IW = $clog2(PALETTE_LENGTH);
  localparam int unsigned PW = (PATTERN_BITS > 1) ? $clog2(PATTERN_BITS) : 1;
  localparam int unsigned CW = 17;
  localparam int unsigned NW = 24;

  localparam logic [2:0] ADDR_ORIGIN  = 3'd0;
  localparam logic [2:0] ADDR_SIZE    = 3'd1;
  localparam logic [2:0] ADDR_COLOR   = 3'd2;
  localparam logic [2:0] ADDR_PATTERN = 3'd3;
  localparam logic [2:0] ADDR_CONTROL = 3'd4;

  localparam logic [1:0] MODE_TRANSPARENT = 2'd1;
  localparam logic [1:0] MODE_OPAQUE      = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [IW-1:0]           fg_q, fg_d, bg_q, bg_d;
  logic [PATTERN_BITS-1:0] pattern_q, pattern_d;
  logic [1:0]              mode_q, mode_d;
  logic [15:0]             x_q, x_d, y_q, y_d;
  logic [AW-1:0]           row_base_q, row_base_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic                    busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [NW-1:0]           count_q, count_d;
  logic                    wr_en_d;
  logic [AW-1:0]           index_d;
  logic [IW-1:0]           value_d;

  // Decoded command strobes and clip window
  logic          ctrl_wr, start_wr, abort_wr, active, accept, advance;
  logic [CW-1:0] x_sum, y_sum, x_end, y_end;
  logic          empty, row_end, last_row;

  // Coordinates of the pixel to present next
  logic          load_px;
  logic [15:0]   px_x, px_y;
  logic [AW-1:0] px_rb;
  logic [PW-1:0] px_p;
  logic [PW-1:0] phase_inc;

  assign ctrl_wr  = reg_wr_en && (reg_addr == ADDR_CONTROL);
  assign start_wr = ctrl_wr && reg_wr_data[0];
  assign abort_wr = ctrl_wr && reg_wr_data[1];
  assign active   = (state_q == SETUP) || (state_q == RUN);
  assign accept   = fb_wr_en && fb_wr_ready;
  // A presented write advances on acceptance; a skipped pixel advances at once
  assign advance  = accept || !fb_wr_en;

  // Geometry registers are frozen while active, so the clip is combinational
  assign x_sum    = {1'b0, x0_q} + {1'b0, w_q};
  assign y_sum    = {1'b0, y0_q} + {1'b0, h_q};
  assign x_end    = (x_sum > CW'(RESOLUTION_X)) ? CW'(RESOLUTION_X) : x_sum;
  assign y_end    = (y_sum > CW'(RESOLUTION_Y)) ? CW'(RESOLUTION_Y) : y_sum;
  assign empty    = ({1'b0, x0_q} >= x_end) || ({1'b0, y0_q} >= y_end);
  assign row_end  = ({1'b0, x_q} + CW'(1)) == x_end;
  assign last_row = ({1'b0, y_q} + CW'(1)) == y_end;

  assign phase_inc = (phase_q == PW'(PATTERN_BITS - 1)) ? '0 : phase_q + PW'(1);

  assign status = {count_q, 5'b0, error_q, done_q, busy_q};

  // State register and datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      fg_q         <= '0;
      bg_q         <= '0;
      pattern_q    <= '0;
      mode_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      row_base_q   <= '0;
      phase_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      count_q      <= '0;
      fb_wr_en     <= 1'b0;
      fb_pxl_index <= '0;
      fb_pxl_value <= '0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      w_q          <= w_d;
      h_q          <= h_d;
      fg_q         <= fg_d;
      bg_q         <= bg_d;
      pattern_q    <= pattern_d;
      mode_q       <= mode_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_base_q   <= row_base_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      count_q      <= count_d;
      fb_wr_en     <= wr_en_d;
      fb_pxl_index <= index_d;
      fb_pxl_value <= value_d;
    end
  end

  // Next-state, register file and pixel sequencing
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    pattern_d  = pattern_q;
    mode_d     = mode_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    phase_d    = phase_q;
    done_d     = done_q;
    error_d    = error_q;
    count_d    = count_q;
    wr_en_d    = fb_wr_en;
    index_d    = fb_pxl_index;
    value_d    = fb_pxl_value;
    load_px    = 1'b0;
    px_x       = x0_q;
    px_y       = y0_q;
    px_rb      = AW'(32'(y0_q) * 32'(RESOLUTION_X));
    px_p       = '0;

    if (reg_wr_en && !active) begin
      case (reg_addr)
        ADDR_ORIGIN:  begin x0_d = reg_wr_data[15:0]; y0_d = reg_wr_data[31:16]; end
        ADDR_SIZE:    begin w_d  = reg_wr_data[15:0]; h_d  = reg_wr_data[31:16]; end
        ADDR_COLOR:   begin fg_d = reg_wr_data[IW-1:0]; bg_d = reg_wr_data[8 +: IW]; end
        ADDR_PATTERN: pattern_d = reg_wr_data[PATTERN_BITS-1:0];
        default:      ;
      endcase
    end

    if (start_wr && active) error_d = 1'b1;
    if (accept) count_d = count_q + NW'(1);

    case (state_q)
      IDLE: begin
        if (start_wr) begin
          state_d = SETUP;
          done_d  = 1'b0;
          error_d = 1'b0;
          count_d = '0;
          mode_d  = reg_wr_data[3:2];
        end
      end
      SETUP: begin
        if (abort_wr || empty) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          load_px = 1'b1;
        end
      end
      RUN: begin
        if (abort_wr) begin
          state_d = DONE;
          wr_en_d = 1'b0;
        end else if (advance) begin
          if (row_end && last_row) begin
            state_d = DONE;
            wr_en_d = 1'b0;
          end else begin
            load_px = 1'b1;
            if (row_end) begin
              px_x  = x0_q;
              px_y  = y_q + 16'd1;
              px_rb = row_base_q + AW'(RESOLUTION_X);
              px_p  = '0;
            end else begin
              px_x  = x_q + 16'd1;
              px_y  = y_q;
              px_rb = row_base_q;
              px_p  = phase_inc;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase

    // Present the selected pixel; transparent mode skips clear pattern bits
    if (load_px) begin
      x_d        = px_x;
      y_d        = px_y;
      row_base_d = px_rb;
      phase_d    = px_p;
      index_d    = px_rb + AW'(px_x);
      wr_en_d    = (mode_q == MODE_TRANSPARENT) ? pattern_q[px_p] : 1'b1;
      value_d    = ((mode_q == MODE_OPAQUE) && !pattern_q[px_p]) ? bg_q : fg_q;
    end

    busy_d = (state_d == SETUP) || (state_d == RUN);
  end

endmodule

// File: tb/tb_display_fill_engine.sv
// Directed testbench for display_fill_engine: solid, clipped, empty, pattern,
// backpressure, abort/error and asynchronous reset scenarios.
module tb_display_fill_engine;

  localparam int unsigned RX = 400;
  localparam int unsigned RY = 300;
  localparam int unsigned AW = $clog2(RX * RY);
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    reg_addr;
  logic [31:0]   reg_wr_data;
  logic          reg_wr_en;
  logic [31:0]   status;
  logic [AW-1:0] fb_pxl_index;
  logic [IW-1:0] fb_pxl_value;
  logic          fb_wr_en;
  logic          fb_wr_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int idx;
    int val;
    int cyc;
  } wr_t;
  wr_t wq[$];

  always #5 clk = ~clk;

  display_fill_engine #(
    .RESOLUTION_X  (RX),
    .RESOLUTION_Y  (RY),
    .PALETTE_LENGTH(256),
    .PATTERN_BITS  (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_en   (reg_wr_en),
    .status      (status),
    .fb_pxl_index(fb_pxl_index),
    .fb_pxl_value(fb_pxl_value),
    .fb_wr_en    (fb_wr_en),
    .fb_wr_ready (fb_wr_ready)
  );

  // Record every accepted framebuffer write with the edge number it happened on
  always @(posedge clk) begin
    if (fb_wr_en && fb_wr_ready)
      wq.push_back('{int'(fb_pxl_index), int'(fb_pxl_value), cyc});
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    reg_addr    = a;
    reg_wr_data = d;
    reg_wr_en   = 1'b1;
    tick();
    reg_wr_en   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (status[1]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wq.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int  e;
    int  n;
    int  bad;
    bit  ok;
    int  solid_idx[6] = '{810, 811, 812, 1210, 1211, 1212};
    int  opq_val[4]   = '{9, 1, 9, 1};

    reset       = 1'b1;
    reg_addr    = '0;
    reg_wr_data = '0;
    reg_wr_en   = 1'b0;
    fb_wr_ready = 1'b1;
    #1;
    check("rst_status", status, 32'd0);
    check("rst_wr_en", 32'(fb_wr_en), 32'd0);
    check("rst_index", 32'(fb_pxl_index), 32'd0);
    check("rst_value", 32'(fb_pxl_value), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Solid 3x2 at (10,2), fg=5
    reg_write(3'd0, 32'h0002_000A);
    reg_write(3'd1, 32'h0002_0003);
    reg_write(3'd2, 32'h0000_0005);
    wq.delete();
    reg_write(3'd4, 32'h0000_0001);
    e = cyc - 1;
    check("solid_busy", 32'(status[0]), 32'd1);
    wait_done(40, ok);
    check("solid_done", 32'(ok), 32'd1);
    check("solid_nwr", wq.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wq.size()) begin
        check("solid_idx", wq[i].idx, solid_idx[i]);
        check("solid_val", wq[i].val, 32'd5);
        check("solid_cyc", wq[i].cyc, e + 2 + i);
      end
    end
    check("solid_count", 32'(status[31:8]), 32'd6);
    check("solid_idle", 32'(status[0]), 32'd0);
    check("solid_err", 32'(status[2]), 32'd0);

    // Clipped at the bottom-right corner
    reg_write(3'd0, 32'h012B_018E);
    reg_write(3'd1, 32'h0004_0005);
    wq.delete();
    reg_write(3'd4, 32'h0000_0001);
    wait_done(40, ok);
    check("clip_done", 32'(ok), 32'd1);
    check("clip_nwr", wq.size(), 32'd2);
    if (wq.size() >= 2) begin
      check("clip_idx0", wq[0].idx, 32'd119998);
      check("clip_idx1", wq[1].idx, 32'd119999);
    end
    check("clip_count", 32'(status[31:8]), 32'd2);

    // Zero width: nothing written, done quickly
    reg_write(3'd1, 32'h0007_0000);
    wq.delete();
    reg_write(3'd4, 32'h0000_0001);
    wait_done(3, ok);
    check("zero_done", 32'(ok), 32'd1);
    check("zero_nwr", wq.size(), 32'd0);
    check("zero_count", 32'(status[31:8]), 32'd0);

    // Transparent pattern 0x5 over 4x1
    reg_write(3'd0, 32'h0000_0000);
    reg_write(3'd1, 32'h0001_0004);
    reg_write(3'd2, 32'h0000_0109);
    reg_write(3'd3, 32'h0000_0005);
    wq.delete();
    reg_write(3'd4, 32'h0000_0005);
    wait_done(40, ok);
    check("transp_done", 32'(ok), 32'd1);
    check("transp_nwr", wq.size(), 32'd2);
    if (wq.size() >= 2) begin
      check("transp_idx0", wq[0].idx, 32'd0);
      check("transp_idx1", wq[1].idx, 32'd2);
      check("transp_val0", wq[0].val, 32'd9);
      check("transp_val1", wq[1].val, 32'd9);
    end
    check("transp_count", 32'(status[31:8]), 32'd2);

    // Opaque pattern 0x5 over 4x1
    wq.delete();
    reg_write(3'd4, 32'h0000_0009);
    wait_done(40, ok);
    check("opq_done", 32'(ok), 32'd1);
    check("opq_nwr", wq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size()) begin
        check("opq_idx", wq[i].idx, i);
        check("opq_val", wq[i].val, opq_val[i]);
      end
    end

    // Backpressure on the second pixel for 3 cycles
    reg_write(3'd2, 32'h0000_0007);
    wq.delete();
    reg_write(3'd4, 32'h0000_0001);
    tick();
    tick();
    check("bp_idx_first", 32'(fb_pxl_index), 32'd1);
    fb_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_idx", 32'(fb_pxl_index), 32'd1);
      check("bp_hold_val", 32'(fb_pxl_value), 32'd7);
      check("bp_hold_en", 32'(fb_wr_en), 32'd1);
    end
    fb_wr_ready = 1'b1;
    wait_done(40, ok);
    check("bp_done", 32'(ok), 32'd1);
    check("bp_nwr", wq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size()) begin
        check("bp_idx", wq[i].idx, i);
        check("bp_val", wq[i].val, 32'd7);
      end
    end
    check("bp_count", 32'(status[31:8]), 32'd4);

    // Restart while busy flags error; abort ends the fill early
    reg_write(3'd1, 32'h0064_0064);
    wq.delete();
    reg_write(3'd4, 32'h0000_0001);
    wait_writes(10, 100, ok);
    check("abort_reach10", 32'(ok), 32'd1);
    reg_write(3'd4, 32'h0000_0001);
    check("abort_err", 32'(status[2]), 32'd1);
    check("abort_still_busy", 32'(status[0]), 32'd1);
    wait_writes(20, 100, ok);
    check("abort_reach20", 32'(ok), 32'd1);
    reg_write(3'd4, 32'h0000_0002);
    tick();
    check("abort_wr_en_low", 32'(fb_wr_en), 32'd0);
    wait_done(10, ok);
    check("abort_done", 32'(ok), 32'd1);
    n = wq.size();
    check("abort_nwr_range", 32'((n >= 20) && (n <= 22)), 32'd1);
    check("abort_count", 32'(status[31:8]), n);
    check("abort_err_sticky", 32'(status[2]), 32'd1);
    bad = 0;
    for (int i = 0; i < n; i++)
      if (wq[i].idx != i) bad++;
    check("abort_seq", bad, 32'd0);

    // Asynchronous reset in the middle of a fill
    reg_write(3'd4, 32'h0000_0001);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_status", status, 32'd0);
    check("arst_wr_en", 32'(fb_wr_en), 32'd0);
    check("arst_index", 32'(fb_pxl_index), 32'd0);
    check("arst_value", 32'(fb_pxl_value), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Normal fill after reset: 2x1 at (5,0), fg=3
    reg_write(3'd0, 32'h0000_0005);
    reg_write(3'd1, 32'h0001_0002);
    reg_write(3'd2, 32'h0000_0003);
    wq.delete();
    reg_write(3'd4, 32'h0000_0001);
    wait_done(40, ok);
    check("post_done", 32'(ok), 32'd1);
    check("post_nwr", wq.size(), 32'd2);
    if (wq.size() >= 2) begin
      check("post_idx0", wq[0].idx, 32'd5);
      check("post_idx1", wq[1].idx, 32'd6);
      check("post_val", wq[1].val, 32'd3);
    end
    check("post_count", 32'(status[31:8]), 32'd2);
    check("post_err", 32'(status[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_fill_engine.md
Name: display_fill_engine

Overview:
Hardware rectangle fill/pattern engine. It is the parametrised successor to the display processor's unimplemented fill/pattern/wmode register set. A CPU-side memory-mapped register port loads a rectangle, colours, a 32-bit line pattern and a mode. On start, the engine streams palette-index writes to the framebuffer write port, one pixel per cycle, under valid/ready backpressure. The rectangle is clipped to the screen.

Parameters:
RESOLUTION_X, 400, framebuffer width in pixels
RESOLUTION_Y, 300, framebuffer height in pixels
PALETTE_LENGTH, 256, palette entries; pixel value width IW = $clog2(PALETTE_LENGTH)
PATTERN_BITS, 32, pattern register width; column phase period

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
reg_addr  in  3  register select: 0 ORIGIN, 1 SIZE, 2 COLOR, 3 PATTERN, 4 CONTROL
reg_wr_data  in  32  register write data
reg_wr_en  in  1  register write strobe
status  out  32  [0] busy, [1] done (sticky), [2] error (sticky), [31:8] pixels written
fb_pxl_index  out  $clog2(RESOLUTION_X*RESOLUTION_Y)  linear pixel address y*RESOLUTION_X+x
fb_pxl_value  out  IW  palette index to write
fb_wr_en  out  1  write valid
fb_wr_ready  in  1  framebuffer accepts the write this cycle

Behaviour:
- Registers:
  - ORIGIN: x0=[15:0], y0=[31:16].
  - SIZE: w=[15:0], h=[31:16].
  - COLOR: fg=[IW-1:0], bg=[8+IW-1:8].
  - PATTERN: [PATTERN_BITS-1:0].
  - CONTROL: [0] start, [1] abort, [3:2] mode. Mode 0 SOLID, 1 TRANSPARENT, 2 OPAQUE, 3 behaves as SOLID.
- Writes to regs 0-3 while busy are ignored. Mode is latched at start.
- Reset (async): state IDLE, all registers 0, status=0, fb_wr_en=0, fb_pxl_index=0, fb_pxl_value=0.
- FSM IDLE:
  - start written (cycle N) -> clear done, error and pixel count; go to SETUP at N+1.
  - abort written in IDLE: no effect.
- FSM SETUP (1 cycle):
  - x_end = min(x0+w, RESOLUTION_X), y_end = min(y0+h, RESOLUTION_Y), 17-bit arithmetic.
  - If x0>=x_end or y0>=y_end -> DONE.
  - Else x=x0, y=y0, row_base=y0*RESOLUTION_X; go to RUN. First fb_wr_en can assert at N+2.
- FSM RUN, per pixel at phase p=(x-x0) mod PATTERN_BITS:
  - SOLID: write fg.
  - TRANSPARENT: write fg if pattern[p]=1; else no write, pixel advances in one cycle with fb_wr_en=0.
  - OPAQUE: write pattern[p] ? fg : bg.
- Handshake:
  - Pixel advances when fb_wr_en&&fb_wr_ready, or on a skipped pixel.
  - While fb_wr_en=1 and fb_wr_ready=0: index and value hold stable, fb_wr_en stays high.
- Advance rule: x+1; at x_end-1 wrap x=x0, y+1, row_base+=RESOLUTION_X (no multiplier in RUN). The last pixel of row y_end-1 completes -> DONE.
- Pixel count increments on each accepted write only, modulo 2^24.
- Abort written in RUN:
  - Accepted at the next pixel boundary; any pending write is dropped immediately.
  - fb_wr_en goes low the next cycle; go to DONE.
- start written while busy: ignored, error<=1.
- Simultaneous start+abort in IDLE: start wins.
- DONE (1 cycle): done<=1, busy<=0, -> IDLE.
- busy=1 in SETUP and RUN.

Test Plan:
- Solid fill: ORIGIN=(10,2), SIZE=(3,2), fg=5, ready=1 -> writes 810, 811, 812, 1210, 1211, 1212, all value 5, on 6 consecutive cycles starting N+2. Then done=1, count=6.
- Clip and zero size: ORIGIN=(398,299), SIZE=(5,4) -> only 119998 and 119999 are written, count=2. A separate run with SIZE=(0,7) -> no writes, done within 3 cycles.
- Pattern modes: PATTERN=0x5, SIZE=(4,1), ORIGIN=(0,0), fg=9, bg=1.
  - TRANSPARENT -> writes index 0 and index 2 with value 9; count=2.
  - OPAQUE -> values 9, 1, 9, 1 at indices 0-3.
- Backpressure: fb_wr_ready low for 3 cycles on the second pixel -> index and value held constant, no duplicate or lost writes, total count correct.
- Abort/error: start a 100x100 fill, write start again at pixel 10 -> error=1 and the fill continues. Write abort at pixel 20 -> fb_wr_en low within 2 cycles, done=1, count≈20.
- Async reset mid-RUN -> all outputs zero immediately, without a clock edge. A subsequent fill runs normally.
